// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage sequencer (master)
// and the variable-latency data memory (slave).
interface mem_stage_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer: turns a single-cycle load/store into a
// req/ack transaction, stalls the upstream pipeline and bubbles MEM/WB until
// the access completes, and captures load data for the MEM/WB result mux.
// Optional feature: define MEM_CTRL_TIMEOUT_EN to add the ACCESS wait counter
// and the sticky FAULT state; without it ACCESS waits for dmem_ack forever.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MEM_memread,
    input  logic                    MEM_memwrite,
    input  logic [31:0]             MEM_addr,
    input  logic [31:0]             MEM_wdata,
    mem_stage_ctrl_if.master        dmem,
    output logic [31:0]             load_data,
    output logic                    mem_stall,
    output logic                    mem_bubble,
    output logic                    mem_fault
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone,
        StFault
    } state_t;

    state_t state_q;
    logic   mem_op;

    assign mem_op = MEM_memread | MEM_memwrite;

    // Reject out-of-range timeouts at elaboration; the counter is 8 bits wide.
    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT must be in 1..255");
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_q;
    logic       fault_q;

    assign mem_fault = fault_q;
`else
    assign mem_fault = 1'b0;
`endif

    // Access sequencer: state, latched bus outputs and captured load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            dmem.dmem_req    <= 1'b0;
            dmem.dmem_we     <= 1'b0;
            dmem.dmem_addr   <= 32'd0;
            dmem.dmem_wdata  <= 32'd0;
            load_data        <= 32'd0;
`ifdef MEM_CTRL_TIMEOUT_EN
            wait_cnt_q       <= 8'd0;
            fault_q          <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_op) begin
                        dmem.dmem_addr  <= MEM_addr;
                        dmem.dmem_wdata <= MEM_wdata;
                        dmem.dmem_req   <= 1'b1;
                        // Store wins when both read and write are flagged.
                        dmem.dmem_we    <= MEM_memwrite;
`ifdef MEM_CTRL_TIMEOUT_EN
                        wait_cnt_q      <= 8'd0;
`endif
                        state_q         <= StAccess;
                    end
                end
                StAccess: begin
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        // dmem_we still reflects this transaction's direction here.
                        if (!dmem.dmem_we) begin
                            load_data <= dmem.dmem_rdata;
                        end
                        state_q <= StDone;
                    end
`ifdef MEM_CTRL_TIMEOUT_EN
                    else if (wait_cnt_q == TimeoutLast) begin
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        fault_q       <= 1'b1;
                        state_q       <= StFault;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Freeze upstream while a memory op is being issued, in flight, or faulted.
    always_comb begin
        mem_stall  = !reset && ((state_q == StIdle && mem_op) ||
                                (state_q == StAccess) ||
                                (state_q == StFault));
        mem_bubble = mem_stall;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] load;
        int          stall;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] load_data;
    logic        mem_stall;
    logic        mem_bubble;
    logic        mem_fault;

    mem_stage_ctrl_if mif ();

    mem_stage_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MEM_memread  (mem_rd),
        .MEM_memwrite (mem_wr),
        .MEM_addr     (mem_addr),
        .MEM_wdata    (mem_wdata),
        .dmem         (mif),
        .load_data    (load_data),
        .mem_stall    (mem_stall),
        .mem_bubble   (mem_bubble),
        .mem_fault    (mem_fault)
    );

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    resp_t       resp_q[$];
    logic [31:0] model_ld;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Memory responder: acks lat cycles after req rises; stray acks when idle.
    int    rsp_cnt;
    logic  rsp_active;
    resp_t rsp_cur;
    initial begin
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'd0;
        rsp_active     = 1'b0;
        rsp_cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            mif.dmem_ack   = 1'b0;
            mif.dmem_rdata = $urandom;
            if (reset) begin
                rsp_active = 1'b0;
            end else if (mif.dmem_req) begin
                if (!rsp_active) begin
                    rsp_active = 1'b1;
                    rsp_cnt    = 0;
                    if (resp_q.size() > 0) rsp_cur = resp_q.pop_front();
                    else rsp_cur = '{0, 32'd0};
                end
                rsp_cnt++;
                if (rsp_cur.lat != 0 && rsp_cnt == rsp_cur.lat) begin
                    mif.dmem_ack   = 1'b1;
                    mif.dmem_rdata = rsp_cur.rdata;
                end
            end else begin
                rsp_active   = 1'b0;
                mif.dmem_ack = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Monitor: checks requests as they appear and each completed stall window.
    logic        req_prev;
    int          run;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        stable_ok;
    exp_t        mon_e;
    initial begin
        req_prev  = 1'b0;
        run       = 0;
        stable_ok = 1'b1;
        cap_addr  = 32'd0;
        cap_wdata = 32'd0;
    end
    always @(negedge clk) begin
        if (reset) begin
            req_prev = 1'b0;
            run      = 0;
        end else begin
            chk("bubble_eq_stall", {31'd0, mem_bubble}, {31'd0, mem_stall});
            if (mif.dmem_req && !req_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    chk("req_we", {31'd0, mif.dmem_we}, {31'd0, exp_q[0].we});
                    chk("req_addr", mif.dmem_addr, exp_q[0].addr);
                    chk("req_wdata", mif.dmem_wdata, exp_q[0].wdata);
                end
                cap_addr  = mif.dmem_addr;
                cap_wdata = mif.dmem_wdata;
                stable_ok = 1'b1;
            end else if (mif.dmem_req) begin
                if (mif.dmem_addr !== cap_addr || mif.dmem_wdata !== cap_wdata) stable_ok = 1'b0;
            end
            req_prev = mif.dmem_req;
            if (mem_stall) begin
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_stall", 32'(run), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stall_len", 32'(run), 32'(mon_e.stall));
                    chk("load_data_done", load_data, mon_e.load);
                    chk("req_low_done", {31'd0, mif.dmem_req}, 32'd0);
                    chk("bus_stable", {31'd0, stable_ok}, 32'd1);
                end
                run = 0;
            end
        end
    end

    // Present one EX/MEM instruction at posedge+1 and hold it until consumed.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rdat);
        int cyc;
        if (rd || wr) begin
            if (rd && !wr) model_ld = rdat;
            exp_q.push_back('{wr, addr, wdata, model_ld, lat + 1});
            resp_q.push_back('{lat, rdat});
        end
        mem_rd    = rd;
        mem_wr    = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        cyc       = 0;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            cyc++;
            if (cyc > 200) begin
                failures++;
                $display("FAIL op_consume_timeout actual=%0d required<=200", cyc);
                finish_tb();
            end
        end
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic flush_after_reset();
        exp_q.delete();
        resp_q.delete();
        model_ld = 32'd0;
    endtask

    int n_req;
    initial begin
        reset     = 1'b1;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        model_ld  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("rst_we", {31'd0, mif.dmem_we}, 32'd0);
        chk("rst_addr", mif.dmem_addr, 32'd0);
        chk("rst_wdata", mif.dmem_wdata, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_fault", {31'd0, mem_fault}, 32'd0);
        mem_rd = 1'b1;
        #1;
        chk("rst_stall_forced_low", {31'd0, mem_stall}, 32'd0);
        chk("rst_bubble_forced_low", {31'd0, mem_bubble}, 32'd0);
        mem_rd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases.
        do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF);
        do_op(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 1, 32'hFFFF_0000);
        do_op(1'b1, 1'b0, 32'h0000_0200, 32'h0, 2, 32'hCAFE_F00D);
        do_op(1'b0, 1'b1, 32'h0000_0204, 32'hA5A5_5A5A, 2, 32'h0BAD_0BAD);
        do_op(1'b1, 1'b1, 32'h0000_0300, 32'h7777_1111, 2, 32'h1357_9BDF);
        do_op(1'b0, 1'b0, 32'h0000_0400, 32'h0, 1, 32'h0);

        // Reset during the second ACCESS cycle.
        exp_q.push_back('{1'b0, 32'h0000_0500, 32'h0, model_ld, 0});
        resp_q.push_back('{0, 32'h0});
        mem_rd   = 1'b1;
        mem_addr = 32'h0000_0500;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
        chk("midrst_addr", mif.dmem_addr, 32'd0);
        chk("midrst_load", load_data, 32'd0);
        mem_rd   = 1'b0;
        mem_addr = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush_after_reset();
        do_op(1'b1, 1'b0, 32'h0000_0600, 32'h0, 2, 32'h600D_DA7A);

        // Ack never returned.
        exp_q.push_back('{1'b0, 32'h0000_0700, 32'h0, model_ld, 0});
        resp_q.push_back('{0, 32'h0});
        mem_rd   = 1'b1;
        mem_addr = 32'h0000_0700;
        n_req    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.dmem_req) n_req++;
        end
`ifdef MEM_CTRL_TIMEOUT_EN
        chk("timeout_access_cycles", 32'(n_req), 32'(TIMEOUT));
        chk("timeout_fault_sticky", {31'd0, mem_fault}, 32'd1);
        chk("timeout_req_low", {31'd0, mif.dmem_req}, 32'd0);
`else
        chk("noto_access_cycles", 32'(n_req), 32'd39);
        chk("noto_fault_low", {31'd0, mem_fault}, 32'd0);
        chk("noto_req_held", {31'd0, mif.dmem_req}, 32'd1);
`endif
        chk("hang_stall_held", {31'd0, mem_stall}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("hang_rst_fault", {31'd0, mem_fault}, 32'd0);
        mem_rd   = 1'b0;
        mem_addr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        flush_after_reset();

        // Randomized mix of loads, stores, both-set and non-memory instructions.
        for (int i = 0; i < 150; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            do_op((kind inside {[3:6], 9}), (kind inside {[7:9]}),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
                  $urandom_range(1, 6), $urandom);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        finish_tb();
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the data-memory access performed in the MEM stage of the 5-stage pipeline. Converts a single-cycle MEM-stage load/store into a request/acknowledge transaction with a variable-latency data memory. Freezes the upstream pipeline and bubbles the MEM/WB register until the access completes. Captures load data so the MEM/WB register can select it in place of the ALU result.

## Interface
Parameters:
- TIMEOUT, 16, max cycles spent in ACCESS waiting for dmem_ack before faulting (legal range 1..255)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset, as already decided
- MEM_memread  in  1  EX/MEM instruction is a load
- MEM_memwrite  in  1  EX/MEM instruction is a store
- MEM_addr  in  32  byte address from EX/MEM ALU result
- MEM_wdata  in  32  store data from EX/MEM
- dmem_req  out  1  request to data memory, registered
- dmem_we  out  1  write enable qualifying dmem_req, registered
- dmem_addr  out  32  latched access address
- dmem_wdata  out  32  latched store data
- dmem_ack  in  1  memory completion, single-cycle pulse
- dmem_rdata  in  32  read data, valid when dmem_ack=1
- load_data  out  32  captured read data, feeds MEM/WB result mux
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- mem_bubble  out  1  force MEM/WB regwrite to 0 this cycle
- mem_fault  out  1  sticky timeout indication

## Operation
- States: IDLE, ACCESS, DONE, FAULT. Reset state IDLE.
- IDLE: if MEM_memread|MEM_memwrite, latch MEM_addr→dmem_addr, MEM_wdata→dmem_wdata, set dmem_req=1, dmem_we=MEM_memwrite, clear wait counter, go ACCESS. Otherwise stay.
- Both memread and memwrite high: store wins (dmem_we=1); load_data not updated.
- ACCESS: dmem_req held 1, address/data stable. On dmem_ack: dmem_req←0, dmem_we←0; if read, load_data←dmem_rdata; go DONE. Else wait counter increments; if counter reaches TIMEOUT-1 without ack, go FAULT (dmem_req←0).
- DONE: exactly one cycle, inputs ignored, then IDLE. The pipeline advances at the end of DONE; MEM/WB captures load_data.
- FAULT: terminal until reset; dmem_req=0, mem_fault=1, mem_stall=1.
- mem_stall = !reset & ((IDLE & (MEM_memread|MEM_memwrite)) | ACCESS | FAULT). Combinational.
- mem_bubble = mem_stall.
- dmem_ack outside ACCESS ignored. load_data holds its value until the next completed read.

## Timing
- Reset values: dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, load_data 0, mem_fault 0. mem_stall and mem_bubble are 0 while reset is high.
- Reset asserted mid-ACCESS: dmem_req drops immediately (async); the transaction is abandoned.
- Ack arriving N cycles after dmem_req rises (N≥1): stall lasts N+1 cycles (IDLE entry cycle plus N in ACCESS). Total access latency is N+2 cycles including DONE.
- Back-to-back memory ops: the second is seen in IDLE the cycle after DONE; no extra gap.
- Non-memory instructions: zero-cycle overhead, stall never asserted.
- Wait counter width 8 bits; never wraps (FAULT taken first).

## Configuration
- MEM_CTRL_TIMEOUT_EN defined: wait counter and FAULT state present as described.
- Not defined: no counter, ACCESS waits indefinitely for dmem_ack, FAULT unreachable, mem_fault tied 0, TIMEOUT unused.

## Test plan
- Load, ack 3 cycles after req, dmem_rdata=0xDEADBEEF → mem_stall high 4 cycles, load_data=0xDEADBEEF in DONE, dmem_req low after ack.
- Store addr 0x100, wdata 0x12345678, ack after 1 cycle → dmem_we=1, dmem_addr/dmem_wdata stable through ACCESS, load_data unchanged, stall 2 cycles.
- Load followed immediately by store, acks after 2 cycles each → two transactions, DONE then IDLE→ACCESS with no idle gap, correct addresses each.
- Ack never returned, TIMEOUT=16 (macro on) → FAULT after 16 ACCESS cycles, mem_fault=1 sticky, stall held; with macro off, stall held, mem_fault=0 indefinitely.
- Reset pulsed in ACCESS cycle 2 → dmem_req=0 asynchronously, all outputs at reset values, next load starts cleanly.
- memread and memwrite both high → dmem_we=1, load_data unchanged after ack.
